// File: rtl/frame_writer.sv
// Streaming Avalon-MM write master that fills a circular frame buffer region,
// either word by word from a valid/ready stream or as a hardware clear.
module frame_writer #(
  parameter int unsigned ADDRESS = 0,
  parameter int unsigned LENGTH  = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  output logic [7:0]  byteenable,
  output logic        write,
  output logic [63:0] writedata,
  input  logic        waitrequest,
  output logic        read,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        fill_start,
  input  logic [63:0] fill_color,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] debug_value0,
  output logic [31:0] debug_value1
);

  localparam int unsigned AW = 29;
  localparam logic [AW-1:0] FIRST = AW'(ADDRESS / 8);
  localparam logic [AW-1:0] LAST  = AW'(ADDRESS / 8 + LENGTH / 8 - 1);

  typedef enum logic [3:0] {
    STREAM     = 4'd0,
    WRITE_WAIT = 4'd1
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] address_n;
  logic          write_n;
  logic [63:0]   writedata_n;
  logic          fill_mode, fill_mode_n;
  logic          frame_done_n;
  logic          at_last;

  assign burstcount = 8'h01;
  assign byteenable = 8'hFF;
  assign read       = 1'b0;
  assign at_last    = (address == LAST);

  assign in_ready = (state == STREAM) && !fill_start && !frame_start;
  assign busy     = !((state == STREAM) && !write);

  assign debug_value0 = {3'b0, waitrequest, 3'b0, write, 3'b0, in_valid,
                         3'b0, in_ready, 3'b0, fill_mode, 3'b0, frame_done,
                         4'b0, state};
  assign debug_value1 = {3'b0, address};

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= STREAM;
      address    <= FIRST;
      write      <= 1'b0;
      writedata  <= 64'd0;
      fill_mode  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      address    <= address_n;
      write      <= write_n;
      writedata  <= writedata_n;
      fill_mode  <= fill_mode_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state logic: fill beats chain back-to-back until the last word of the frame.
  always_comb begin
    state_n      = state;
    address_n    = address;
    write_n      = write;
    writedata_n  = writedata;
    fill_mode_n  = fill_mode;
    frame_done_n = 1'b0;

    case (state)
      STREAM: begin
        if (fill_start) begin
          address_n   = FIRST;
          writedata_n = fill_color;
          fill_mode_n = 1'b1;
          write_n     = 1'b1;
          state_n     = WRITE_WAIT;
        end else if (frame_start) begin
          address_n = FIRST;
        end else if (in_valid) begin
          writedata_n = in_data;
          write_n     = 1'b1;
          state_n     = WRITE_WAIT;
        end
      end

      WRITE_WAIT: begin
        if (!waitrequest) begin
          if (at_last) begin
            address_n    = FIRST;
            frame_done_n = 1'b1;
          end else begin
            address_n = address + AW'(1);
          end
          if (fill_mode && !at_last) begin
            write_n = 1'b1;
          end else begin
            write_n     = 1'b0;
            fill_mode_n = 1'b0;
            state_n     = STREAM;
          end
        end
      end

      default: begin
        state_n = STREAM;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_writer.sv
// Randomised bench for frame_writer: a frame-offset model predicts every output
// each cycle, and directed phases pin the model with literal expectations.
module tb_frame_writer;

  localparam int unsigned ADDR  = 32'h1000;
  localparam int unsigned LEN   = 32;
  localparam int unsigned N     = LEN / 8;
  localparam logic [28:0] FIRST = 29'h200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [28:0] address;
  logic [7:0]  burstcount, byteenable;
  logic        write, read;
  logic [63:0] writedata;
  logic        waitrequest;
  logic [63:0] in_data;
  logic        in_valid, in_ready;
  logic        fill_start, frame_start;
  logic [63:0] fill_color;
  logic        busy, frame_done;
  logic [31:0] debug_value0, debug_value1;

  frame_writer #(.ADDRESS(ADDR), .LENGTH(LEN)) dut (
    .clock(clk), .reset_n(reset_n), .address(address), .burstcount(burstcount),
    .byteenable(byteenable), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .read(read), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fill_start(fill_start), .fill_color(fill_color),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .debug_value0(debug_value0), .debug_value1(debug_value1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  int done_cnt = 0;

  // Model: a pending job covers m_left consecutive frame offsets starting at m_ptr.
  bit          m_busy = 1'b0, m_fill = 1'b0, m_done = 1'b0;
  int          m_ptr = 0, m_left = 0;
  logic [63:0] m_data = 64'd0;

  logic [28:0] log_addr[$];
  logic [63:0] log_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit b, f, d;
    int p, l;
    logic [63:0] dt;
    b = m_busy; f = m_fill; p = m_ptr; l = m_left; dt = m_data; d = 1'b0;
    if (!reset_n) begin
      b = 1'b0; f = 1'b0; p = 0; l = 0; dt = 64'd0;
    end else if (!b) begin
      if (fill_start) begin
        p = 0; dt = fill_color; b = 1'b1; f = 1'b1; l = N;
      end else if (frame_start) begin
        p = 0;
      end else if (in_valid) begin
        dt = in_data; b = 1'b1; l = 1;
      end
    end else if (!waitrequest) begin
      if (p == N - 1) d = 1'b1;
      p = (p + 1) % N;
      l = l - 1;
      if (l == 0) begin
        b = 1'b0; f = 1'b0;
      end
    end
    m_busy <= b; m_fill <= f; m_ptr <= p; m_left <= l; m_data <= dt; m_done <= d;
  end

  // Record writes the DUT completes on the bus.
  always @(posedge clk) begin
    if (reset_n && write === 1'b1 && waitrequest == 1'b0) begin
      log_addr.push_back(address);
      log_data.push_back(writedata);
    end
  end

  always @(negedge clk) begin
    logic        exp_ready;
    logic [28:0] exp_addr;
    logic [31:0] exp_dbg0;
    if (frame_done === 1'b1) done_cnt++;
    if (check_en) begin
      exp_ready = !m_busy && !fill_start && !frame_start;
      exp_addr  = FIRST + 29'(m_ptr);
      exp_dbg0  = {3'b0, waitrequest, 3'b0, m_busy, 3'b0, in_valid, 3'b0, exp_ready,
                   3'b0, m_fill, 3'b0, m_done, 4'b0, (m_busy ? 4'd1 : 4'd0)};
      chk("address", 64'(address), 64'(exp_addr));
      chk("write", 64'(write), 64'(m_busy));
      if (m_busy) chk("writedata", writedata, m_data);
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("consts", 64'({burstcount, byteenable, read}), 64'({8'h01, 8'hFF, 1'b0}));
      chk("debug_value0", 64'(debug_value0), 64'(exp_dbg0));
      chk("debug_value1", 64'(debug_value1), 64'({3'b0, exp_addr}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      tick();
      n++;
    end
    n_chk++;
    if (m_busy) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic stream_word(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    wait_idle(20);
  endtask

  initial begin
    int d0;
    reset_n = 1'b0; waitrequest = 1'b0; in_valid = 1'b0; in_data = 64'd0;
    fill_start = 1'b0; fill_color = 64'd0; frame_start = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    chk("reset address", 64'(address), 64'h200);
    chk("reset write", 64'(write), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    reset_n = 1'b1;
    tick();

    // Five stream words wrap once around the 4-word frame.
    log_addr.delete(); log_data.delete();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) stream_word(64'hA0 + 64'(i));
    tick();
    chk("stream count", 64'(log_addr.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      chk("stream addr", 64'(log_addr[i]), 64'(29'h200 + 29'(i % 4)));
      chk("stream data", log_data[i], 64'hA0 + 64'(i));
    end
    chk("stream frame_done", 64'(done_cnt - d0), 64'd1);

    // Backpressure on one word.
    log_addr.delete(); log_data.delete();
    waitrequest = 1'b1; in_valid = 1'b1; in_data = 64'hB0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp address", 64'(address), 64'h201);
      chk("bp writedata", writedata, 64'hB0);
      tick();
    end
    waitrequest = 1'b0;
    tick();
    chk("bp count", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() > 0) chk("bp log", {log_addr[0], log_data[0][34:0]}, {29'h201, 35'hB0});
    chk("bp advance", 64'(address), 64'h202);

    // Hardware fill.
    log_addr.delete(); log_data.delete();
    d0 = done_cnt;
    fill_start = 1'b1; fill_color = 64'hFFFF;
    tick();
    fill_start = 1'b0;
    wait_idle(20);
    tick();
    chk("fill count", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("fill addr", 64'(log_addr[i]), 64'(29'h200 + 29'(i)));
      chk("fill data", log_data[i], 64'hFFFF);
    end
    chk("fill frame_done", 64'(done_cnt - d0), 64'd1);
    chk("fill end address", 64'(address), 64'h200);
    chk("fill end state", 64'(debug_value0[3:0]), 64'd0);

    // Fill beats a simultaneous stream word.
    log_addr.delete(); log_data.delete();
    fill_start = 1'b1; fill_color = 64'h5555; in_valid = 1'b1; in_data = 64'hDEAD;
    #1;
    chk("collide in_ready", 64'(in_ready), 64'd0);
    tick();
    fill_start = 1'b0; in_valid = 1'b0;
    wait_idle(20);
    chk("collide count", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < log_addr.size(); i++) chk("collide data", log_data[i], 64'h5555);

    // Reset in the middle of a fill.
    fill_start = 1'b1; fill_color = 64'h77;
    tick();
    fill_start = 1'b0;
    tick();
    chk("midfill address", 64'(address), 64'h201);
    reset_n = 1'b0; waitrequest = 1'b1;
    tick();
    chk("midfill reset write", 64'(write), 64'd0);
    chk("midfill reset address", 64'(address), 64'h200);
    chk("midfill reset state", 64'(debug_value0[3:0]), 64'd0);
    reset_n = 1'b1; waitrequest = 1'b0;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(1) == 1);
      in_data     = {$urandom, $urandom};
      waitrequest = ($urandom_range(9) < 3);
      fill_start  = ($urandom_range(49) == 0);
      fill_color  = {$urandom, $urandom};
      frame_start = ($urandom_range(29) == 0);
      reset_n     = ($urandom_range(199) != 0);
      tick();
    end
    reset_n = 1'b1; in_valid = 1'b0; fill_start = 1'b0; frame_start = 1'b0; waitrequest = 1'b0;
    wait_idle(20);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Streaming SDRAM write master that fills the LCD frame buffer region that the display path reads. It accepts 64-bit words on a valid/ready stream and writes them to consecutive 64-bit addresses over the Avalon-MM SDRAM port, wrapping at the end of the frame. It also supports a hardware clear that fills the whole frame with one word. Renderer-side logic produces pixels; this block gets them into memory.

## Interface
- ADDRESS, 0: byte address of frame start; multiple of 8. FIRST = ADDRESS/8.
- LENGTH, 0: frame size in bytes; multiple of 8, ≥8. LAST = FIRST + LENGTH/8 − 1.
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- address  out  29  64-bit word address.
- burstcount  out  8  constant 8'h01.
- byteenable  out  8  constant 8'hFF.
- write  out  1  Avalon write request.
- writedata  out  64  Avalon write data.
- waitrequest  in  1  Avalon stall.
- read  out  1  constant 0.
- in_data  in  64  stream word.
- in_valid  in  1  stream word present.
- in_ready  out  1  block accepts word this cycle.
- fill_start  in  1  start frame fill (sampled in STREAM).
- fill_color  in  64  fill word, sampled with fill_start.
- frame_start  in  1  resync write pointer to FIRST (sampled in STREAM).
- busy  out  1  high unless in STREAM with write low.
- frame_done  out  1  one-cycle pulse after write to LAST completes.
- debug_value0  out  32  {3'b0,waitrequest, 3'b0,write, 3'b0,in_valid, 3'b0,in_ready, 3'b0,fill_mode, 3'b0,frame_done, 4'b0, state}.
- debug_value1  out  32  {3'b0, address}.

## Operation
- States (4-bit): STREAM=0, WRITE_WAIT=1, default → STREAM. Internal fill_mode flag.
- Reset (reset_n low at a clock edge): state=STREAM, address=FIRST, write=0, writedata=0, fill_mode=0, frame_done=0. Reset mid-write drops write immediately; the in-flight word is discarded.
- in_ready = (state==STREAM) && !fill_start && !frame_start (combinational).
- STREAM, priority order:
  - fill_start: address←FIRST, writedata←fill_color, fill_mode←1, write←1, →WRITE_WAIT.
  - else frame_start: address←FIRST; stay.
  - else in_valid: writedata←in_data, write←1, →WRITE_WAIT.
- WRITE_WAIT: write, address, writedata held stable while waitrequest=1. On waitrequest=0:
  - If address==LAST: address←FIRST, frame_done←1 for one cycle.
  - Else: address←address+1.
  - If fill_mode and address!=LAST: write stays 1 (next fill beat, same writedata); remain in WRITE_WAIT.
  - Otherwise: write←0, fill_mode←0, →STREAM.
- Stream inputs are ignored outside in_ready; fill_start/frame_start outside STREAM are ignored (not queued).
- Address arithmetic: 29-bit, wraps only at LAST; never exceeds LAST.

## Timing
- Stream: handshake at edge N → write=1 from N+1; with waitrequest=0 at N+1, write=0 at N+2, in_ready=1 at N+2. Peak 1 word / 2 clocks.
- Fill: one word per clock when waitrequest=0; LENGTH/8 beats; frame_done at the cycle after the LAST beat is accepted, together with write=0.
- frame_done is registered; high exactly one cycle per completed frame.
- busy is combinational from state/write.

## Test plan
- Reset: ADDRESS=0x1000, LENGTH=32 (FIRST=0x200, LAST=0x203); hold reset_n=0 3 cycles -> address=0x200, write=0, in_ready=1, frame_done=0.
- Stream 5 words 0xA0..0xA4, waitrequest=0 -> writes to 0x200,0x201,0x202,0x203,0x200 with matching data; frame_done pulses once after 0x203.
- Backpressure: waitrequest=1 for 4 cycles on word 0xB0 -> address/writedata stable, in_ready=0 throughout; one write accepted; address advances by 1.
- Fill: fill_start=1, fill_color=0xFFFF, waitrequest=0 -> 4 consecutive write beats 0x200..0x203 of 0xFFFF, frame_done one cycle, return to STREAM with address=0x200.
- Simultaneous fill_start and in_valid in STREAM -> fill wins, in_ready=0, stream word not consumed.
- Reset asserted during a fill at address 0x201 -> next cycle write=0, address=0x200, state=STREAM.
